// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access pipeline stage; non-memory results pass
// straight through, loads/stores run byte-serially over an 8-bit port.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rdy                global ready; state and counters hold while low
//   ex_we/waddr/wdata  register-write result from EX
//   ex_memop           0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU,
//                      6 SB, 7 SH, 8 SW, 9-15 none
//   ex_mem_addr        effective byte address
//   ex_store_data      store data, little-endian
//   mem_din, mem_done  read byte and per-byte completion
//   mem_req, mem_wr    byte request and direction
//   mem_addr, mem_dout byte address and write byte
//   stall_req          freezes IF..MA while an access is in flight
//   ma_we/waddr/wdata  result to MA/WB
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  input  logic [7:0]  mem_din,
  input  logic        mem_done,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        stall_req,
  output logic        ma_we,
  output logic [4:0]  ma_waddr,
  output logic [31:0] ma_wdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  byte_cnt;
  logic [2:0]  nbytes;
  logic [31:0] ldbuf;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [2:0]  size;
  logic        last_byte;
  logic [31:0] ld_ext;
  logic [4:0]  lane;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 3'd1;
    unique case (1'b1)
      (ex_memop == 4'd1),
      (ex_memop == 4'd4): begin
        is_load = 1'b1;
        size    = 3'd1;
      end
      (ex_memop == 4'd2),
      (ex_memop == 4'd5): begin
        is_load = 1'b1;
        size    = 3'd2;
      end
      (ex_memop == 4'd3): begin
        is_load = 1'b1;
        size    = 3'd4;
      end
      (ex_memop == 4'd6): begin
        is_store = 1'b1;
        size     = 3'd1;
      end
      (ex_memop == 4'd7): begin
        is_store = 1'b1;
        size     = 3'd2;
      end
      (ex_memop == 4'd8): begin
        is_store = 1'b1;
        size     = 3'd4;
      end
      default: ;
    endcase
  end

  assign is_mem    = is_load | is_store;
  assign lane      = {byte_cnt, 3'b000};
  assign last_byte = ({1'b0, byte_cnt} == (nbytes - 3'd1));

  always_comb begin
    unique case (ex_memop)
      4'd1:    ld_ext = {{24{ldbuf[7]}}, ldbuf[7:0]};
      4'd2:    ld_ext = {{16{ldbuf[15]}}, ldbuf[15:0]};
      4'd4:    ld_ext = {24'd0, ldbuf[7:0]};
      4'd5:    ld_ext = {16'd0, ldbuf[15:0]};
      default: ld_ext = ldbuf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      ldbuf    <= 32'd0;
      nbytes   <= 3'd1;
    end else if (rdy) begin
      state <= state_n;
      if (state == IDLE && is_mem) begin
        byte_cnt <= 2'd0;
        ldbuf    <= 32'd0;
        nbytes   <= size;
      end else if (state == BUSY && mem_done) begin
        if (is_load)
          ldbuf[lane +: 8] <= mem_din;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'd0;
    mem_dout  = 8'd0;
    stall_req = 1'b0;
    ma_we     = 1'b0;
    ma_waddr  = 5'd0;
    ma_wdata  = 32'd0;
    unique case (state)
      IDLE: begin
        if (is_mem) begin
          stall_req = 1'b1;
          state_n   = BUSY;
        end else begin
          ma_we    = ex_we;
          ma_waddr = ex_waddr;
          ma_wdata = ex_wdata;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        mem_req   = 1'b1;
        mem_wr    = is_store;
        mem_addr  = ex_mem_addr + {30'd0, byte_cnt};
        mem_dout  = ex_store_data[lane +: 8];
        if (mem_done && last_byte)
          state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        if (is_load) begin
          ma_we    = ex_we;
          ma_waddr = ex_waddr;
          ma_wdata = ld_ext;
        end
      end
      default: state_n = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, even mid-access.
    if (rst) begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 32'd0;
      mem_dout  = 8'd0;
      stall_req = 1'b0;
      ma_we     = 1'b0;
      ma_waddr  = 5'd0;
      ma_wdata  = 32'd0;
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access (MA) stage of the RISC-V core pipeline, between the EX/MA pipeline register and the MA/WB register. Non-memory instructions pass their register-write result straight through. Loads and stores are executed byte-serially over the 8-bit memory-controller port, with a stall request held until the access completes. It produces `ma_we`/`ma_waddr`/`ma_wdata` for MA/WB.

## Interface
Parameters: none.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready; FSM and counters freeze while low.
- `ex_we` in 1: register-write enable from EX.
- `ex_waddr` in 5: destination register.
- `ex_wdata` in 32: ALU result; selected for non-memory ops.
- `ex_memop` in 4: 0=none, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW; 9–15 treated as none.
- `ex_mem_addr` in 32: effective byte address.
- `ex_store_data` in 32: store data, little-endian byte order.
- `mem_din` in 8: read byte; valid when `mem_done`=1.
- `mem_done` in 1: current byte transfer completes this cycle.
- `mem_req` out 1: byte transfer request.
- `mem_wr` out 1: 1=write, 0=read.
- `mem_addr` out 32: byte address.
- `mem_dout` out 8: write byte.
- `stall_req` out 1: asks the pipeline controller to freeze IF..MA (stall[3:0]).
- `ma_we` out 1, `ma_waddr` out 5, `ma_wdata` out 32: result to MA/WB.

## Operation
- Inputs `ex_*` stay stable while `stall_req`=1; the upstream pipeline guarantees this.
- States: IDLE, BUSY, DONE. Internal: `byte_cnt` (2 bits), `nbytes` (1/2/4), 32-bit `ldbuf`.
- IDLE:
  - memop none: `ma_*` = `ex_*`, `stall_req`=0, `mem_req`=0.
  - memop valid: `stall_req`=1, `ma_we`=0; next state BUSY; clear `byte_cnt` and `ldbuf`; latch `nbytes` (B=1, H=2, W=4).
- BUSY:
  - Outputs: `stall_req`=1, `mem_req`=1, `mem_wr`=1 for SB/SH/SW; `mem_addr` = `ex_mem_addr` + `byte_cnt` (32-bit, wraps mod 2^32); `mem_dout` = `ex_store_data[8*byte_cnt +: 8]`; `ma_we`=0.
  - On `mem_done`: for loads, `ldbuf[8*byte_cnt +: 8]` <= `mem_din`; then `byte_cnt`++.
  - When `mem_done` and `byte_cnt` = `nbytes`−1, next state is DONE.
  - No alignment check: misaligned addresses are transferred byte by byte.
- DONE (exactly one cycle, then IDLE):
  - `stall_req`=0, `mem_req`=0.
  - Loads: `ma_we`=`ex_we`, `ma_waddr`=`ex_waddr`, `ma_wdata` = extended `ldbuf`. LB sign-extends from bit 7, LH from bit 15, LBU/LHU zero-extend, LW uses it unchanged.
  - Stores: `ma_we`=0, `ma_waddr`=0, `ma_wdata`=0.
- `ex_waddr`=0 is passed through unchanged; the register file ignores x0.

## Timing
- While `rst`=1, all outputs are 0; this is forced combinationally, like the WB stage. On the clock edge with `rst`=1: state→IDLE, `byte_cnt`=0, `ldbuf`=0.
- Reset mid-access abandons the transfer: `mem_req`=0 from the cycle `rst` is sampled, and there is no write-back.
- `rdy`=0: state, `byte_cnt` and `ldbuf` hold; `mem_done` is ignored; outputs keep their last combinational values for the held state.
- Non-memory op: zero added latency; the result is present the same cycle.
- n-byte access with `mem_done` every cycle: `stall_req` is high for n+1 cycles (IDLE + n BUSY), and the result appears in the following DONE cycle. MA/WB captures it on the DONE→IDLE edge.
- `mem_done` asserted in IDLE or DONE is ignored.
- Back-to-back memory ops: the DONE cycle always separates them; the next op starts in IDLE on the cycle after DONE.

## Test plan
- ALU pass-through: `ex_memop`=0, `ex_we`=1, `ex_waddr`=5, `ex_wdata`=0x1234 → same cycle `ma_*`=(1,5,0x1234), `stall_req`=0, `mem_req`=0.
- LW at 0x100, memory returns 0x78,0x56,0x34,0x12 with `mem_done` every cycle:
  - `mem_addr` steps through 0x100..0x103.
  - `stall_req` is high for 5 cycles.
  - DONE cycle: `ma_wdata`=0x12345678, `ma_we`=1.
- LB/LBU at 0x7 returning 0x80: LB gives `ma_wdata`=0xFFFFFF80; LBU gives 0x00000080. Repeat LH with bytes 0x00,0x80 → 0xFFFF8000.
- SH at 0x2001, data 0xAABBCCDD, `mem_done` delayed 3 cycles per byte:
  - Writes 0xDD@0x2001, then 0xCC@0x2002.
  - `mem_wr`=1 throughout.
  - DONE: `ma_we`=0.
  - `stall_req` is high for 1+2×4=9 cycles.
- SW at 0xFFFFFFFE wraps: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Assert `rst` after the 2nd byte of an LW → next cycle `mem_req`=0, state IDLE, no `ma_we` pulse. Separately, drop `rdy` for 3 cycles mid-LW → `byte_cnt` holds and the final data is correct.
